// File: rtl/expr_evaluator_pkg.sv
// Shared types and constants for the expression evaluator.
// Also used by the serial BCD converter.
package expr_evaluator_pkg;

  localparam int CALC_STEPS = 4;
  localparam int RES_W      = 7;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  localparam int NUM1_HI = 11;
  localparam int NUM1_LO = 8;
  localparam int OP_HI   = 7;
  localparam int OP_LO   = 4;
  localparam int NUM2_HI = 3;
  localparam int NUM2_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_CONV,
    S_DONE
  } state_e;

  function automatic logic legal_digit(input logic [3:0] d);
    return (d >= 4'd1) && (d <= 4'd9);
  endfunction

  function automatic logic legal_op(input logic [3:0] o);
    return (o >= OP_ADD) && (o <= OP_DIV);
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: 7-bit binary to two BCD digits.
// Takes RES_W edges after start; bcd holds until the next conversion.
module bin2bcd_serial
  import expr_evaluator_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic             last,
  output logic [7:0]       bcd
);

  localparam int W = RES_W + 8;

  logic [W-1:0] work;
  logic [W-1:0] work_n;
  logic [2:0]   cnt;

  function automatic logic [W-1:0] dabble(input logic [W-1:0] w);
    logic [3:0] t;
    logic [3:0] o;
    t = w[W-1:W-4];
    o = w[W-5:W-8];
    if (t >= 4'd5) t = t + 4'd3;
    if (o >= 4'd5) o = o + 4'd3;
    return {t[2:0], o, w[RES_W-1:0], 1'b0};
  endfunction

  assign work_n = dabble(work);
  assign last   = (cnt == 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work <= '0;
      cnt  <= '0;
      bcd  <= '0;
    end else if (start) begin
      work <= {8'd0, bin};
      cnt  <= 3'(RES_W);
    end else if (cnt != 3'd0) begin
      work <= work_n;
      cnt  <= cnt - 3'd1;
      if (last) bcd <= work_n[W-1:RES_W];
    end
  end

endmodule

// File: rtl/expr_evaluator.sv
// Evaluates {num1, op, num2} with fixed latency and
// reports binary, remainder and BCD forms of the answer.
module expr_evaluator
  import expr_evaluator_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] exp_in,
  input  logic [1:0]  line_in,
  input  logic        req,
  output logic        busy,
  output logic        done,
  output logic [6:0]  result,
  output logic [3:0]  remainder,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic        neg,
  output logic        err,
  output logic [1:0]  line_out
);

  state_e state, state_n;

  logic [3:0] num1;
  logic [3:0] op;
  logic [3:0] num2;
  logic [1:0] line;
  logic       bad;
  logic [7:0] acc, acc_n;
  logic [3:0] rem, rem_n;
  logic       sub_neg, sub_neg_n;
  logic [1:0] step;
  logic [4:0] div_t;
  logic       capture;
  logic       calc_last;
  logic       conv_last;
  logic       bcd_last;
  logic [6:0] mag;
  logic [7:0] bcd;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign capture   = req && (state == S_IDLE || state == S_DONE);
  assign calc_last = (state == S_CALC) && (step == 2'(CALC_STEPS - 1));
  assign conv_last = (state == S_CONV) && bcd_last;
  assign mag       = bad ? 7'd0 : acc_n[6:0];
  assign bcd_tens  = bcd[7:4];
  assign bcd_ones  = bcd[3:0];

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (req) state_n = S_CALC;
      S_CALC:  if (calc_last) state_n = S_CONV;
      S_CONV:  if (conv_last) state_n = S_DONE;
      S_DONE:  state_n = req ? S_CALC : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // add/sub settle on the first step; mul/div use all four
  always_comb begin
    acc_n     = acc;
    rem_n     = rem;
    sub_neg_n = sub_neg;
    div_t     = {rem, num1[2'd3 - step]};
    unique case (1'b1)
      op == OP_ADD: begin
        if (step == 2'd0)
          acc_n = {4'd0, num1} + {4'd0, num2};
      end
      op == OP_SUB: begin
        if (step == 2'd0) begin
          sub_neg_n = (num1 < num2);
          acc_n = (num1 < num2) ? {4'd0, num2 - num1}
                                : {4'd0, num1 - num2};
        end
      end
      op == OP_MUL: begin
        if (num2[step])
          acc_n = acc + ({4'd0, num1} << step);
      end
      op == OP_DIV: begin
        if (div_t >= {1'b0, num2}) begin
          rem_n = 4'(div_t - {1'b0, num2});
          acc_n = {acc[6:0], 1'b1};
        end else begin
          rem_n = div_t[3:0];
          acc_n = {acc[6:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      num1      <= '0;
      op        <= '0;
      num2      <= '0;
      line      <= '0;
      bad       <= 1'b0;
      acc       <= '0;
      rem       <= '0;
      sub_neg   <= 1'b0;
      step      <= '0;
      result    <= '0;
      remainder <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
      line_out  <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        num1    <= exp_in[NUM1_HI:NUM1_LO];
        op      <= exp_in[OP_HI:OP_LO];
        num2    <= exp_in[NUM2_HI:NUM2_LO];
        line    <= line_in;
        bad     <= !(legal_digit(exp_in[NUM1_HI:NUM1_LO]) &&
                     legal_digit(exp_in[NUM2_HI:NUM2_LO]) &&
                     legal_op(exp_in[OP_HI:OP_LO]));
        acc     <= '0;
        rem     <= '0;
        sub_neg <= 1'b0;
        step    <= '0;
      end else if (state == S_CALC) begin
        step <= step + 2'd1;
        if (!bad) begin
          acc     <= acc_n;
          rem     <= rem_n;
          sub_neg <= sub_neg_n;
        end
      end
      if (conv_last) begin
        result    <= acc[6:0];
        remainder <= rem;
        neg       <= sub_neg;
        err       <= bad;
        line_out  <= line;
      end
    end
  end

  bin2bcd_serial u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (calc_last),
    .bin   (mag),
    .last  (bcd_last),
    .bcd   (bcd)
  );

endmodule
